// File: rtl/rs_pkg.sv
// Shared constants and forwarding-bus match helper for the reservation station array.
// Callers zero-pad bus vectors up to FWD_MAX buses of TAG_MAX-bit tags.
package rs_pkg;

    localparam int FWD_MAX   = 8;
    localparam int TAG_MAX   = 8;
    localparam int FWD_IDX_W = 3;

    localparam logic [TAG_MAX-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic                 hit;
        logic [FWD_IDX_W-1:0] idx;
    } fwd_hit_t;

    // Lowest-index valid bus carrying the tag wins; TAG_NONE never matches.
    function automatic fwd_hit_t fwd_match(
        input logic [TAG_MAX-1:0]         tag,
        input logic [FWD_MAX-1:0]         bus_valid,
        input logic [FWD_MAX*TAG_MAX-1:0] bus_tag
    );
        fwd_hit_t r;
        r.hit = 1'b0;
        r.idx = '0;
        for (int b = FWD_MAX - 1; b >= 0; b--) begin
            if (tag != TAG_NONE && bus_valid[b] && bus_tag[b*TAG_MAX +: TAG_MAX] == tag) begin
                r.hit = 1'b1;
                r.idx = FWD_IDX_W'(b);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_operand_slot.sv
// One operand's tag/value register: loads from allocation, shifts in from the next slot,
// and captures forwarded values. RS_WAKEUP_BYPASS_EN exposes same-cycle wakeup on sel_*_o.
module rs_operand_slot
    import rs_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int TAG_W   = 4,
    parameter int NUM_FWD = 3
) (
    input  logic                      clk_i,
    input  logic [NUM_FWD-1:0]        fwd_valid_i,
    input  logic [NUM_FWD*TAG_W-1:0]  fwd_tag_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_val_i,
    input  logic                      load_i,
    input  logic [TAG_W-1:0]          load_tag_i,
    input  logic [DATA_W:0]           load_val_i,
    input  logic                      shift_i,
    input  logic [TAG_W-1:0]          shift_tag_i,
    input  logic [DATA_W-1:0]         shift_val_i,
    output logic [TAG_W-1:0]          tag_o,
    output logic [DATA_W-1:0]         val_o,
    output logic [TAG_W-1:0]          sel_tag_o,
    output logic [DATA_W-1:0]         sel_val_o
);

    logic [TAG_W-1:0]           tag_q, tag_d, src_tag;
    logic [DATA_W-1:0]          val_q, val_d, src_val, src_bus_val;
    logic [FWD_MAX-1:0]         bus_valid_pad;
    logic [FWD_MAX*TAG_MAX-1:0] bus_tag_pad;
    fwd_hit_t                   src_hit;

    always_comb begin
        bus_valid_pad = '0;
        bus_tag_pad   = '0;
        for (int b = 0; b < NUM_FWD; b++) begin
            bus_valid_pad[b]                   = fwd_valid_i[b];
            bus_tag_pad[b*TAG_MAX +: TAG_MAX]  = TAG_MAX'(fwd_tag_i[b*TAG_W +: TAG_W]);
        end
    end

    // A value-valid allocation is treated as tag 0 so it never matches a bus.
    always_comb begin
        src_tag = tag_q;
        src_val = val_q;
        if (load_i) begin
            src_tag = load_val_i[DATA_W] ? '0 : load_tag_i;
            src_val = load_val_i[DATA_W-1:0];
        end else if (shift_i) begin
            src_tag = shift_tag_i;
            src_val = shift_val_i;
        end
        src_hit     = fwd_match(TAG_MAX'(src_tag), bus_valid_pad, bus_tag_pad);
        src_bus_val = '0;
        for (int b = 0; b < NUM_FWD; b++) begin
            if (FWD_IDX_W'(b) == src_hit.idx) src_bus_val = fwd_val_i[b*DATA_W +: DATA_W];
        end
        tag_d = src_hit.hit ? '0 : src_tag;
        val_d = src_hit.hit ? src_bus_val : src_val;
    end

    always_ff @(posedge clk_i) begin
        tag_q <= tag_d;
        val_q <= val_d;
    end

    assign tag_o = tag_q;
    assign val_o = val_q;

`ifdef RS_WAKEUP_BYPASS_EN
    fwd_hit_t          own_hit;
    logic [DATA_W-1:0] own_bus_val;

    always_comb begin
        own_hit     = fwd_match(TAG_MAX'(tag_q), bus_valid_pad, bus_tag_pad);
        own_bus_val = '0;
        for (int b = 0; b < NUM_FWD; b++) begin
            if (FWD_IDX_W'(b) == own_hit.idx) own_bus_val = fwd_val_i[b*DATA_W +: DATA_W];
        end
        sel_tag_o = own_hit.hit ? '0 : tag_q;
        sel_val_o = own_hit.hit ? own_bus_val : val_q;
    end
`else
    assign sel_tag_o = tag_q;
    assign sel_val_o = val_q;
`endif

endmodule

// File: rtl/reservation_station_array.sv
// Collapsing-queue reservation station: age-ordered select, flush, allocation-time forwarding.
// Optional RS_WAKEUP_BYPASS_EN allows issue in the same cycle the last operand wakes up.
module reservation_station_array
    import rs_pkg::*;
#(
    parameter int ENTRIES  = 4,
    parameter int NUM_SRC  = 3,
    parameter int NUM_FWD  = 3,
    parameter int DATA_W   = 64,
    parameter int CMD_W    = 10,
    parameter int ROB_SIZE = 8,
    parameter int TAG_W    = $clog2(ROB_SIZE + 1)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          flush_i,
    input  logic                          alloc_valid_i,
    output logic                          alloc_ready_o,
    input  logic [NUM_SRC*TAG_W-1:0]      alloc_tag_i,
    input  logic [NUM_SRC*(DATA_W+1)-1:0] alloc_val_i,
    input  logic [CMD_W-1:0]              alloc_cmd_i,
    input  logic [TAG_W-1:0]              alloc_dest_i,
    input  logic [NUM_FWD-1:0]            fwd_valid_i,
    input  logic [NUM_FWD*TAG_W-1:0]      fwd_tag_i,
    input  logic [NUM_FWD*DATA_W-1:0]     fwd_val_i,
    output logic                          issue_valid_o,
    input  logic                          issue_ready_i,
    output logic [NUM_SRC*DATA_W-1:0]     issue_val_o,
    output logic [CMD_W-1:0]              issue_cmd_o,
    output logic [TAG_W-1:0]              issue_dest_o,
    output logic [$clog2(ENTRIES+1)-1:0]  count_o
);

    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam int SEL_W = $clog2(ENTRIES);

    logic [CNT_W-1:0]   count_q, count_d, alloc_slot;
    logic [ENTRIES-1:0] ready, load_en, shift_en;
    logic [SEL_W-1:0]   sel_idx;
    logic               sel_found, issue_fire, alloc_fire;

    logic [TAG_W-1:0]  op_tag  [ENTRIES][NUM_SRC];
    logic [DATA_W-1:0] op_val  [ENTRIES][NUM_SRC];
    logic [TAG_W-1:0]  sel_tag [ENTRIES][NUM_SRC];
    logic [DATA_W-1:0] sel_val [ENTRIES][NUM_SRC];
    logic [CMD_W-1:0]  cmd_arr [ENTRIES];
    logic [TAG_W-1:0]  dest_arr[ENTRIES];

    // Full is judged on the registered count only, keeping issue_ready_i off the alloc_ready_o path.
    assign alloc_ready_o = (count_q != CNT_W'(ENTRIES));
    assign count_o       = count_q;
    assign issue_valid_o = sel_found;

    always_comb begin
        ready = '0;
        for (int j = 0; j < ENTRIES; j++) begin
            ready[j] = (j < int'(count_q));
            for (int s = 0; s < NUM_SRC; s++) begin
                if (sel_tag[j][s] != '0) ready[j] = 1'b0;
            end
        end
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int j = ENTRIES - 1; j >= 0; j--) begin
            if (ready[j]) begin
                sel_found = 1'b1;
                sel_idx   = SEL_W'(j);
            end
        end
        issue_fire = sel_found & issue_ready_i & ~flush_i;
        alloc_fire = alloc_valid_i & alloc_ready_o & ~flush_i;
        alloc_slot = issue_fire ? count_q - CNT_W'(1) : count_q;
        for (int j = 0; j < ENTRIES; j++) begin
            shift_en[j] = issue_fire && (j >= int'(sel_idx)) && (j + 1 < int'(count_q));
            load_en[j]  = alloc_fire && (CNT_W'(j) == alloc_slot);
        end
        count_d = flush_i ? '0 : count_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end

    always_comb begin
        issue_val_o  = '0;
        issue_cmd_o  = '0;
        issue_dest_o = '0;
        if (sel_found) begin
            for (int s = 0; s < NUM_SRC; s++) issue_val_o[s*DATA_W +: DATA_W] = sel_val[sel_idx][s];
            issue_cmd_o  = cmd_arr[sel_idx];
            issue_dest_o = dest_arr[sel_idx];
        end
    end

    for (genvar j = 0; j < ENTRIES; j++) begin : g_entry
        // The top slot never shifts; pointing it at itself keeps the index in range.
        localparam int NXT = (j == ENTRIES - 1) ? j : j + 1;

        logic [CMD_W-1:0] cmd_q, cmd_d;
        logic [TAG_W-1:0] dest_q, dest_d;

        always_comb begin
            cmd_d  = cmd_q;
            dest_d = dest_q;
            if (load_en[j]) begin
                cmd_d  = alloc_cmd_i;
                dest_d = alloc_dest_i;
            end else if (shift_en[j]) begin
                cmd_d  = cmd_arr[NXT];
                dest_d = dest_arr[NXT];
            end
        end

        always_ff @(posedge clk_i) begin
            cmd_q  <= cmd_d;
            dest_q <= dest_d;
        end

        assign cmd_arr[j]  = cmd_q;
        assign dest_arr[j] = dest_q;

        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            rs_operand_slot #(
                .DATA_W (DATA_W),
                .TAG_W  (TAG_W),
                .NUM_FWD(NUM_FWD)
            ) u_slot (
                .clk_i      (clk_i),
                .fwd_valid_i(fwd_valid_i),
                .fwd_tag_i  (fwd_tag_i),
                .fwd_val_i  (fwd_val_i),
                .load_i     (load_en[j]),
                .load_tag_i (alloc_tag_i[s*TAG_W +: TAG_W]),
                .load_val_i (alloc_val_i[s*(DATA_W+1) +: DATA_W+1]),
                .shift_i    (shift_en[j]),
                .shift_tag_i(op_tag[NXT][s]),
                .shift_val_i(op_val[NXT][s]),
                .tag_o      (op_tag[j][s]),
                .val_o      (op_val[j][s]),
                .sel_tag_o  (sel_tag[j][s]),
                .sel_val_o  (sel_val[j][s])
            );
        end
    end

endmodule

// File: tb/tb_reservation_station_array.sv
// Bench for reservation_station_array: directed scenarios plus random traffic against a queue model.
module tb_reservation_station_array;

    localparam int ENTRIES = 4;
    localparam int NSRC    = 3;
    localparam int NFWD    = 3;
    localparam int DW      = 64;
    localparam int CW      = 10;
    localparam int TW      = 4;

    logic                   clk = 1'b0;
    logic                   reset_i, flush_i, alloc_valid_i, alloc_ready_o;
    logic [NSRC*TW-1:0]     alloc_tag_i;
    logic [NSRC*(DW+1)-1:0] alloc_val_i;
    logic [CW-1:0]          alloc_cmd_i;
    logic [TW-1:0]          alloc_dest_i;
    logic [NFWD-1:0]        fwd_valid_i;
    logic [NFWD*TW-1:0]     fwd_tag_i;
    logic [NFWD*DW-1:0]     fwd_val_i;
    logic                   issue_valid_o, issue_ready_i;
    logic [NSRC*DW-1:0]     issue_val_o;
    logic [CW-1:0]          issue_cmd_o;
    logic [TW-1:0]          issue_dest_o;
    logic [2:0]             count_o;

    reservation_station_array #(
        .ENTRIES(ENTRIES), .NUM_SRC(NSRC), .NUM_FWD(NFWD),
        .DATA_W(DW), .CMD_W(CW), .ROB_SIZE(8)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_tag_i(alloc_tag_i), .alloc_val_i(alloc_val_i),
        .alloc_cmd_i(alloc_cmd_i), .alloc_dest_i(alloc_dest_i),
        .fwd_valid_i(fwd_valid_i), .fwd_tag_i(fwd_tag_i), .fwd_val_i(fwd_val_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_val_o(issue_val_o), .issue_cmd_o(issue_cmd_o),
        .issue_dest_o(issue_dest_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0]           cmd;
        logic [TW-1:0]           dest;
        logic [NSRC-1:0][TW-1:0] tag;
        logic [NSRC-1:0][DW-1:0] val;
    } ent_t;

    ent_t q[$];
    int   exp_sel;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit bus_hit(input logic [TW-1:0] t, output logic [DW-1:0] v);
        bit found = 1'b0;
        v = '0;
        for (int b = 0; b < NFWD; b++) begin
            if (!found && t != 0 && fwd_valid_i[b] && fwd_tag_i[b*TW +: TW] == t) begin
                found = 1'b1;
                v     = fwd_val_i[b*DW +: DW];
            end
        end
        return found;
    endfunction

    task automatic check_outputs();
        ent_t e;
        exp_sel = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (exp_sel < 0 && q[i].tag == '0) exp_sel = i;
        end
        chk("count", 256'(count_o), 256'(q.size()));
        chk("alloc_ready", 256'(alloc_ready_o), 256'(q.size() < ENTRIES));
        chk("issue_valid", 256'(issue_valid_o), 256'(exp_sel >= 0));
        if (exp_sel >= 0) begin
            e = q[exp_sel];
            chk("issue_cmd", 256'(issue_cmd_o), 256'(e.cmd));
            chk("issue_dest", 256'(issue_dest_o), 256'(e.dest));
            chk("issue_val", 256'(issue_val_o), 256'(e.val));
        end
    endtask

    task automatic model_step();
        ent_t          e;
        logic [DW-1:0] v;
        bit            full;
        full = (q.size() == ENTRIES);
        if (flush_i) begin
            q.delete();
        end else begin
            if (exp_sel >= 0 && issue_ready_i) q.delete(exp_sel);
            for (int i = 0; i < q.size(); i++) begin
                e = q[i];
                for (int s = 0; s < NSRC; s++) begin
                    if (e.tag[s] != 0 && bus_hit(e.tag[s], v)) begin
                        e.tag[s] = '0;
                        e.val[s] = v;
                    end
                end
                q[i] = e;
            end
            if (alloc_valid_i && !full) begin
                e.cmd  = alloc_cmd_i;
                e.dest = alloc_dest_i;
                for (int s = 0; s < NSRC; s++) begin
                    if (alloc_val_i[s*(DW+1) + DW]) begin
                        e.tag[s] = '0;
                        e.val[s] = alloc_val_i[s*(DW+1) +: DW];
                    end else if (bus_hit(alloc_tag_i[s*TW +: TW], v)) begin
                        e.tag[s] = '0;
                        e.val[s] = v;
                    end else begin
                        e.tag[s] = alloc_tag_i[s*TW +: TW];
                        e.val[s] = '0;
                    end
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        flush_i       = 1'b0;
        alloc_valid_i = 1'b0;
        alloc_tag_i   = '0;
        alloc_val_i   = '0;
        alloc_cmd_i   = '0;
        alloc_dest_i  = '0;
        fwd_valid_i   = '0;
        fwd_tag_i     = '0;
        fwd_val_i     = '0;
    endtask

    task automatic put_alloc(input logic [CW-1:0] cmd, input logic [TW-1:0] dest,
                             input logic [NSRC*TW-1:0] tags, input logic [NSRC-1:0] vmask,
                             input logic [NSRC*DW-1:0] vals);
        alloc_valid_i = 1'b1;
        alloc_cmd_i   = cmd;
        alloc_dest_i  = dest;
        alloc_tag_i   = tags;
        for (int s = 0; s < NSRC; s++) alloc_val_i[s*(DW+1) +: DW+1] = {vmask[s], vals[s*DW +: DW]};
    endtask

    task automatic put_fwd(input int b, input logic [TW-1:0] t, input logic [DW-1:0] v);
        fwd_valid_i[b]        = 1'b1;
        fwd_tag_i[b*TW +: TW] = t;
        fwd_val_i[b*DW +: DW] = v;
    endtask

    task automatic rand_inputs();
        idle();
        issue_ready_i = ($urandom_range(0, 3) != 0);
        flush_i       = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 1) == 1) begin
            alloc_valid_i = 1'b1;
            alloc_cmd_i   = CW'($urandom);
            alloc_dest_i  = TW'($urandom);
            for (int s = 0; s < NSRC; s++) begin
                alloc_tag_i[s*TW +: TW]         = TW'($urandom_range(1, 8));
                alloc_val_i[s*(DW+1) +: DW+1]   = {1'($urandom_range(0, 1)), $urandom, $urandom};
            end
        end
        for (int b = 0; b < NFWD; b++) begin
            if ($urandom_range(0, 2) == 0) put_fwd(b, TW'($urandom_range(1, 8)), {$urandom, $urandom});
        end
    endtask

    task automatic do_flush();
        idle();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
    endtask

    initial begin
        reset_i       = 1'b1;
        issue_ready_i = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk("rst_count", 256'(count_o), 256'(0));
        chk("rst_issue_valid", 256'(issue_valid_o), 256'(0));
        chk("rst_alloc_ready", 256'(alloc_ready_o), 256'(1));
        chk("rst_issue_val", 256'(issue_val_o), 256'(0));
        chk("rst_issue_cmd", 256'(issue_cmd_o), 256'(0));

        // all operands valid at allocation
        put_alloc(10, 1, '0, 3'b111, {64'hC, 64'hB, 64'hA});
        cycle();
        idle();
        #1;
        chk("t1_valid", 256'(issue_valid_o), 256'(1));
        chk("t1_val", 256'(issue_val_o), 256'({64'hC, 64'hB, 64'hA}));
        chk("t1_cmd", 256'(issue_cmd_o), 256'(10));
        cycle();
        #1;
        chk("t1_count", 256'(count_o), 256'(0));
        cycle();

        // two forwarded operands, bus2 then bus0
        put_alloc(11, 2, {4'd0, 4'd4, 4'd3}, 3'b100, {64'h33, 64'h0, 64'h0});
        cycle();
        idle();
        put_fwd(2, 4'd3, 64'hF0);
        cycle();
        idle();
        put_fwd(0, 4'd4, 64'hD1);
        cycle();
        idle();
        #1;
        chk("t2_val", 256'(issue_val_o), 256'({64'h33, 64'hD1, 64'hF0}));
        cycle();

        // bus priority on wakeup
        put_alloc(12, 3, {4'd0, 4'd0, 4'd5}, 3'b110, {64'h2, 64'h1, 64'h0});
        cycle();
        idle();
        put_fwd(0, 4'd5, 64'h11);
        put_fwd(1, 4'd5, 64'h22);
        cycle();
        idle();
        #1;
        chk("t3_prio", 256'(issue_val_o[63:0]), 256'(64'h11));
        cycle();
        do_flush();

        // fill, then make slot 2 ready
        issue_ready_i = 1'b0;
        for (int k = 0; k < ENTRIES; k++) begin
            idle();
            put_alloc(CW'(20 + k), TW'(k), {4'd0, 4'd0, TW'(k + 1)}, 3'b110, {64'h5, 64'h6, 64'h0});
            cycle();
        end
        idle();
        #1;
        chk("t4_full_ready", 256'(alloc_ready_o), 256'(0));
        put_fwd(0, 4'd3, 64'h77);
        cycle();
        idle();
        issue_ready_i = 1'b1;
        #1;
        chk("t4_sel_cmd", 256'(issue_cmd_o), 256'(22));
        cycle();
        issue_ready_i = 1'b0;
        put_alloc(30, 7, '0, 3'b111, {64'h9, 64'h8, 64'h7});
        cycle();
        idle();
        issue_ready_i = 1'b1;
        #1;
        chk("t4_new_cmd", 256'(issue_cmd_o), 256'(30));
        cycle();
        do_flush();

        // forward in the allocation cycle
        put_alloc(13, 4, {4'd0, 4'd0, 4'd6}, 3'b110, {64'h2, 64'h1, 64'h0});
        put_fwd(1, 4'd6, 64'h55);
        cycle();
        idle();
        #1;
        chk("t5_alloc_fwd", 256'(issue_val_o[63:0]), 256'(64'h55));
        cycle();

        // stall then flush
        issue_ready_i = 1'b0;
        put_alloc(40, 5, '0, 3'b111, {64'h3, 64'h2, 64'h1});
        cycle();
        idle();
        repeat (3) cycle();
        flush_i       = 1'b1;
        issue_ready_i = 1'b1;
        put_alloc(41, 6, '0, 3'b111, {64'h3, 64'h2, 64'h1});
        cycle();
        idle();
        #1;
        chk("t6_flush_count", 256'(count_o), 256'(0));
        chk("t6_flush_valid", 256'(issue_valid_o), 256'(0));
        cycle();

        for (int n = 0; n < 1500; n++) begin
            rand_inputs();
            cycle();
        end

        // async reset with entries present
        do_flush();
        issue_ready_i = 1'b1;
        put_alloc(50, 1, {4'd0, 4'd0, 4'd7}, 3'b110, '0);
        cycle();
        put_alloc(51, 2, '0, 3'b111, {64'h1, 64'h2, 64'h3});
        cycle();
        idle();
        #2;
        reset_i = 1'b1;
        #1;
        chk("rst2_count", 256'(count_o), 256'(0));
        chk("rst2_issue_valid", 256'(issue_valid_o), 256'(0));
        chk("rst2_alloc_ready", 256'(alloc_ready_o), 256'(1));
        chk("rst2_issue_cmd", 256'(issue_cmd_o), 256'(0));
        q.delete();
        @(negedge clk);
        reset_i = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
